// File: rtl/imem_responder_if.sv
// Fetch, response and load signals between a fetch master and the instruction-memory responder.
interface imem_responder_if #(
  parameter int unsigned ADDR_BITS = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_instr;
  logic                 rsp_error;
  logic                 load_en;
  logic [ADDR_BITS-1:0] load_addr;
  logic [31:0]          load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_error
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed wait states, then a held response.
module imem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                clock,
  input logic                nreset,
  imem_responder_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem_q [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] word_idx;
  logic                 addr_bad;
  logic [31:0]          rd_word;

  assign word_idx = addr_q[ADDR_BITS+1:2];
  assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_BITS+2] != '0);
  // Read sees the pre-edge contents, so a same-edge load returns the old word.
  assign rd_word  = mem_q[word_idx];

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_error = rsp_error_q;

  // Word storage; not reset, writes suppressed while reset is asserted.
  always_ff @(posedge clock) begin
    if (nreset && bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // State, counter, latched address and response registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_instr_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Next-state: accept in idle, count down wait states, hold response until handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_instr_d = rsp_instr_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          if (addr_bad) begin
            rsp_instr_d = 32'd0;
            rsp_error_d = 1'b1;
          end else begin
            rsp_instr_d = rd_word;
            rsp_error_d = 1'b0;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
